// File: rtl/dm_arb_pkg.sv
// rtl/dm_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dm_arb_pkg;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_e;

  localparam logic [31:0] BWEB_IDLE        = 32'hFFFF_FFFF;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/dm_arb_starve_cnt.sv
// rtl/dm_arb_starve_cnt.sv - counts consecutive cycles the DMA port waited without a grant
module dm_arb_starve_cnt
  import dm_arb_pkg::*;
#(
  parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dma_req,
  input  logic       dma_gnt,
  output logic [3:0] starve_cnt
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  // Count lost DMA cycles, saturating at the limit; any grant or dropped request restarts the count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= 4'd0;
    end else if (!dma_req || dma_gnt) begin
      starve_cnt <= 4'd0;
    end else if (starve_cnt != LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - two-port (CPU/DMA) arbiter in front of a single-port data SRAM
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int unsigned CPU_PRIORITY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [31:0] cpu_bweb,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [13:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic [31:0] dma_bweb,
  output logic        cpu_gnt,
  output logic        dma_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic        dma_rvalid,
  output logic [31:0] cpu_rdata,
  output logic [31:0] dma_rdata,
  output logic        DM_WEB,
  output logic [31:0] DM_BWEB,
  output logic [13:0] DM_A,
  output logic [31:0] DM_IN,
  input  logic [31:0] DM_OUT
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  port_e      last_gnt;
  port_e      rd_owner;
  logic       rd_pend;
  logic       dma_wins;

  dm_arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst       (rst),
    .dma_req   (dma_req),
    .dma_gnt   (dma_gnt),
    .starve_cnt(starve_cnt)
  );

  // Decide who takes a conflict: starvation override in priority mode, alternation in round-robin mode
  always_comb begin
    dma_wins = 1'b0;
    if (CPU_PRIORITY != 0) begin
      dma_wins = (starve_cnt == LIM);
    end else begin
      dma_wins = (last_gnt == PORT_CPU);
    end
  end

  // Grants are combinational so a lone requester is served in the cycle it asks
  assign cpu_gnt   = ~rst & cpu_req & ~(dma_req & dma_wins);
  assign dma_gnt   = ~rst & dma_req & ~(cpu_req & ~dma_wins);
  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Steer the granted port's fields onto the SRAM; idle values otherwise
  always_comb begin
    DM_WEB  = 1'b1;
    DM_BWEB = BWEB_IDLE;
    DM_A    = 14'd0;
    DM_IN   = 32'd0;
    if (cpu_gnt) begin
      DM_WEB  = ~cpu_we;
      DM_BWEB = cpu_we ? cpu_bweb : BWEB_IDLE;
      DM_A    = cpu_addr;
      DM_IN   = cpu_wdata;
    end else if (dma_gnt) begin
      DM_WEB  = ~dma_we;
      DM_BWEB = dma_we ? dma_bweb : BWEB_IDLE;
      DM_A    = dma_addr;
      DM_IN   = dma_wdata;
    end
  end

  // Remember the most recent winner for round-robin; DMA after reset so the CPU wins first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= PORT_DMA;
    end else if (cpu_gnt) begin
      last_gnt <= PORT_CPU;
    end else if (dma_gnt) begin
      last_gnt <= PORT_DMA;
    end
  end

  // Capture the owner of a granted read so next cycle's SRAM data goes only to that port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend  <= 1'b0;
      rd_owner <= PORT_CPU;
    end else begin
      rd_pend  <= (cpu_gnt & ~cpu_we) | (dma_gnt & ~dma_we);
      rd_owner <= dma_gnt ? PORT_DMA : PORT_CPU;
    end
  end

  assign cpu_rvalid = rd_pend & (rd_owner == PORT_CPU);
  assign dma_rvalid = rd_pend & (rd_owner == PORT_DMA);
  assign cpu_rdata  = cpu_rvalid ? DM_OUT : 32'd0;
  assign dma_rdata  = dma_rvalid ? DM_OUT : 32'd0;

endmodule

// File: tb/tb_dm_arbiter.sv
// tb/tb_dm_arbiter.sv - scoreboard bench for dm_arbiter in priority and round-robin modes
module tb_dm_arbiter;

  typedef struct {
    logic        req;
    logic        we;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] bweb;
  } rq_t;

  typedef struct {
    int          cyc;
    bit          port;
    logic [31:0] data;
  } exp_t;

  localparam int LIM0 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic n_rst;

  rq_t cur_cpu[2], cur_dma[2], n_cpu[2], n_dma[2];
  logic [31:0] dm_out[2];
  logic [31:0] dout_next[2];
  logic [31:0] dout_force[2];
  bit          dout_force_en[2];

  logic        cpu_gnt[2], dma_gnt[2], cpu_stall[2], cpu_rvalid[2], dma_rvalid[2], dm_web[2];
  logic [31:0] cpu_rdata[2], dma_rdata[2], dm_bweb[2], dm_in[2];
  logic [13:0] dm_a[2];

  int   starve_m[2];
  int   last_m[2];
  int   win_m[2];
  exp_t sb[2][$];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.STARVE_LIMIT(LIM0), .CPU_PRIORITY(1)) u_fp (
    .clk(clk), .rst(rst),
    .cpu_req(cur_cpu[0].req), .cpu_we(cur_cpu[0].we), .cpu_addr(cur_cpu[0].addr),
    .cpu_wdata(cur_cpu[0].wdata), .cpu_bweb(cur_cpu[0].bweb),
    .dma_req(cur_dma[0].req), .dma_we(cur_dma[0].we), .dma_addr(cur_dma[0].addr),
    .dma_wdata(cur_dma[0].wdata), .dma_bweb(cur_dma[0].bweb),
    .cpu_gnt(cpu_gnt[0]), .dma_gnt(dma_gnt[0]), .cpu_stall(cpu_stall[0]),
    .cpu_rvalid(cpu_rvalid[0]), .dma_rvalid(dma_rvalid[0]),
    .cpu_rdata(cpu_rdata[0]), .dma_rdata(dma_rdata[0]),
    .DM_WEB(dm_web[0]), .DM_BWEB(dm_bweb[0]), .DM_A(dm_a[0]), .DM_IN(dm_in[0]),
    .DM_OUT(dm_out[0])
  );

  dm_arbiter #(.STARVE_LIMIT(LIM0), .CPU_PRIORITY(0)) u_rr (
    .clk(clk), .rst(rst),
    .cpu_req(cur_cpu[1].req), .cpu_we(cur_cpu[1].we), .cpu_addr(cur_cpu[1].addr),
    .cpu_wdata(cur_cpu[1].wdata), .cpu_bweb(cur_cpu[1].bweb),
    .dma_req(cur_dma[1].req), .dma_we(cur_dma[1].we), .dma_addr(cur_dma[1].addr),
    .dma_wdata(cur_dma[1].wdata), .dma_bweb(cur_dma[1].bweb),
    .cpu_gnt(cpu_gnt[1]), .dma_gnt(dma_gnt[1]), .cpu_stall(cpu_stall[1]),
    .cpu_rvalid(cpu_rvalid[1]), .dma_rvalid(dma_rvalid[1]),
    .cpu_rdata(cpu_rdata[1]), .dma_rdata(dma_rdata[1]),
    .DM_WEB(dm_web[1]), .DM_BWEB(dm_bweb[1]), .DM_A(dm_a[1]), .DM_IN(dm_in[1]),
    .DM_OUT(dm_out[1])
  );

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endfunction

  function automatic rq_t idle_rq();
    rq_t r;
    r.req = 1'b0; r.we = 1'b0; r.addr = 14'd0; r.wdata = 32'd0; r.bweb = 32'hFFFF_FFFF;
    return r;
  endfunction

  function automatic rq_t mk_rq(logic we, logic [13:0] addr, logic [31:0] wdata, logic [31:0] bweb);
    rq_t r;
    r.req = 1'b1; r.we = we; r.addr = addr; r.wdata = wdata; r.bweb = bweb;
    return r;
  endfunction

  function automatic rq_t rand_rq();
    rq_t r;
    r.req   = ($urandom_range(0, 3) != 0);
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = 14'($urandom());
    r.wdata = $urandom();
    r.bweb  = $urandom();
    return r;
  endfunction

  // Reference: who wins, starvation bookkeeping in lost cycles, and which read data is owed next cycle
  task automatic model(int i);
    bit c, d, dma_pref;
    int w;
    c = cur_cpu[i].req;
    d = cur_dma[i].req;
    if (rst) begin
      win_m[i] = 0; starve_m[i] = 0; last_m[i] = 2; sb[i].delete();
      return;
    end
    if (i == 0) dma_pref = (starve_m[i] >= LIM0);
    else        dma_pref = (last_m[i] == 1);
    if (c && d)  w = dma_pref ? 2 : 1;
    else if (c)  w = 1;
    else if (d)  w = 2;
    else         w = 0;
    win_m[i] = w;
    if (d && w != 2) starve_m[i] = (starve_m[i] < LIM0) ? starve_m[i] + 1 : LIM0;
    else             starve_m[i] = 0;
    if (w != 0) last_m[i] = w;
    if (w == 1 && !cur_cpu[i].we) sb[i].push_back('{cyc + 1, 1'b0, dout_next[i]});
    if (w == 2 && !cur_dma[i].we) sb[i].push_back('{cyc + 1, 1'b1, dout_next[i]});
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    rst = n_rst;
    for (int i = 0; i < 2; i++) begin
      cur_cpu[i] = n_cpu[i];
      cur_dma[i] = n_dma[i];
      dm_out[i]  = dout_next[i];
      dout_next[i] = dout_force_en[i] ? dout_force[i] : $urandom();
      dout_force_en[i] = 1'b0;
      model(i);
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rq_t r;
      string t;
      t = (i == 0) ? "fp" : "rr";
      r = (win_m[i] == 2) ? cur_dma[i] : cur_cpu[i];
      chk({t, ".cpu_gnt"}, 32'(cpu_gnt[i]), 32'(win_m[i] == 1));
      chk({t, ".dma_gnt"}, 32'(dma_gnt[i]), 32'(win_m[i] == 2));
      chk({t, ".cpu_stall"}, 32'(cpu_stall[i]), 32'(cur_cpu[i].req && win_m[i] != 1));
      if (win_m[i] == 0) begin
        chk({t, ".DM_WEB"}, 32'(dm_web[i]), 32'd1);
        chk({t, ".DM_BWEB"}, dm_bweb[i], 32'hFFFF_FFFF);
        chk({t, ".DM_A"}, 32'(dm_a[i]), 32'd0);
        chk({t, ".DM_IN"}, dm_in[i], 32'd0);
      end else begin
        chk({t, ".DM_WEB"}, 32'(dm_web[i]), 32'(!r.we));
        chk({t, ".DM_BWEB"}, dm_bweb[i], r.we ? r.bweb : 32'hFFFF_FFFF);
        chk({t, ".DM_A"}, 32'(dm_a[i]), 32'(r.addr));
        chk({t, ".DM_IN"}, dm_in[i], r.wdata);
      end
    end
  endtask

  // Monitor: pop owed read data and compare against what each port presents
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        bit ecv, edv;
        logic [31:0] ed;
        ecv = 1'b0; edv = 1'b0; ed = 32'd0;
        while (sb[i].size() > 0 && sb[i][0].cyc < cyc) begin
          chk($sformatf("inst%0d.stale_read", i), 32'(sb[i][0].cyc), 32'(cyc));
          void'(sb[i].pop_front());
        end
        if (sb[i].size() > 0 && sb[i][0].cyc == cyc) begin
          exp_t e;
          e = sb[i].pop_front();
          ecv = !e.port; edv = e.port; ed = e.data;
        end
        chk($sformatf("inst%0d.cpu_rvalid", i), 32'(cpu_rvalid[i]), 32'(ecv));
        chk($sformatf("inst%0d.dma_rvalid", i), 32'(dma_rvalid[i]), 32'(edv));
        chk($sformatf("inst%0d.cpu_rdata", i), cpu_rdata[i], ecv ? ed : 32'd0);
        chk($sformatf("inst%0d.dma_rdata", i), dma_rdata[i], edv ? ed : 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] obs_fp, obs_st, obs_rr;
    n_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cur_cpu[i] = idle_rq(); cur_dma[i] = idle_rq();
      n_cpu[i] = idle_rq();
      n_dma[i] = mk_rq(1'b0, 14'h3, 32'd0, 32'd0);
      dm_out[i] = 32'd0; dout_next[i] = $urandom(); dout_force_en[i] = 1'b0;
      starve_m[i] = 0; last_m[i] = 2; win_m[i] = 0;
    end

    // Reset holds with a DMA request pending: no grants, idle SRAM, no rvalid
    repeat (3) cycle();

    // Continuous contention straight out of reset
    n_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cpu[i] = mk_rq(1'b0, 14'h011, 32'd0, 32'd0);
      n_dma[i] = mk_rq(1'b0, 14'h022, 32'd0, 32'd0);
    end
    for (int k = 0; k < 10; k++) begin
      cycle();
      obs_fp[k] = dma_gnt[0];
      obs_st[k] = cpu_stall[0];
      obs_rr[k] = dma_gnt[1];
    end
    chk("fp.dma_pattern", 32'(obs_fp), 32'(10'b10000_10000));
    chk("fp.stall_pattern", 32'(obs_st), 32'(10'b10000_10000));
    chk("rr.dma_pattern", 32'(obs_rr), 32'(10'b10101_01010));

    for (int i = 0; i < 2; i++) begin n_cpu[i] = idle_rq(); n_dma[i] = idle_rq(); end
    cycle();

    // Lone CPU read of DEADBEEF
    n_cpu[0] = mk_rq(1'b0, 14'h010, 32'd0, 32'd0);
    dout_force[0] = 32'hDEADBEEF; dout_force_en[0] = 1'b1;
    cycle();
    chk("read.same_cycle_gnt", 32'(cpu_gnt[0]), 32'd1);
    n_cpu[0] = idle_rq();
    cycle();
    chk("read.cpu_rvalid", 32'(cpu_rvalid[0]), 32'd1);
    chk("read.cpu_rdata", cpu_rdata[0], 32'hDEADBEEF);
    chk("read.dma_rdata", dma_rdata[0], 32'd0);

    // DMA masked write
    n_dma[0] = mk_rq(1'b1, 14'h020, 32'h12345678, 32'hFFFF_0000);
    cycle();
    chk("wr.DM_WEB", 32'(dm_web[0]), 32'd0);
    chk("wr.DM_BWEB", dm_bweb[0], 32'hFFFF_0000);
    chk("wr.DM_A", 32'(dm_a[0]), 32'h020);
    chk("wr.DM_IN", dm_in[0], 32'h12345678);
    n_dma[0] = idle_rq();
    cycle();
    chk("wr.no_rvalid", 32'(dma_rvalid[0]), 32'd0);

    // Alternating single-port reads, no bubbles
    for (int k = 0; k < 6; k++) begin
      n_cpu[0] = (k % 2 == 0) ? mk_rq(1'b0, 14'($urandom()), 32'd0, 32'd0) : idle_rq();
      n_dma[0] = (k % 2 == 1) ? mk_rq(1'b0, 14'($urandom()), 32'd0, 32'd0) : idle_rq();
      cycle();
      if (k > 0) chk("alt.rvalid_port", 32'({cpu_rvalid[0], dma_rvalid[0]}), (k % 2 == 1) ? 32'd2 : 32'd1);
    end
    n_cpu[0] = idle_rq(); n_dma[0] = idle_rq();
    cycle();

    // Reset pulse right after a granted CPU read
    n_cpu[0] = mk_rq(1'b0, 14'h004, 32'd0, 32'd0);
    cycle();
    n_cpu[0] = idle_rq();
    n_rst = 1'b1;
    cycle();
    chk("rstmid.cpu_rvalid", 32'(cpu_rvalid[0]), 32'd0);
    cycle();
    n_rst = 1'b0;
    cycle();
    chk("rstmid.after_deassert", 32'(cpu_rvalid[0]), 32'd0);

    // Randomized traffic with request hold-until-grant and occasional resets
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!(cur_cpu[i].req && win_m[i] != 1) || rst) n_cpu[i] = rand_rq();
        if (!(cur_dma[i].req && win_m[i] != 2) || rst) n_dma[i] = rand_rq();
      end
      n_rst = ($urandom_range(0, 199) == 0);
      cycle();
    end

    n_rst = 1'b0;
    for (int i = 0; i < 2; i++) begin n_cpu[i] = idle_rq(); n_dma[i] = idle_rq(); end
    repeat (3) cycle();
    chk("drain.fp", 32'(sb[0].size()), 32'd0);
    chk("drain.rr", 32'(sb[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
